// File: rtl/airi5c_float_mul_arbiter.sv
// Round-robin arbiter sharing one multi-cycle float multiplier between two
// requesters, with load/kill sequencing, result capture and a watchdog.
module airi5c_float_mul_arbiter #(
    parameter int WDOG_CYCLES = 8
) (
    input  logic        clk,
    input  logic        n_reset,
    input  logic        kill,
    input  logic        req0_valid,
    input  logic [38:0] req0_a,
    input  logic [38:0] req0_b,
    output logic        req0_ready,
    output logic        req0_done,
    input  logic        req1_valid,
    input  logic [38:0] req1_a,
    input  logic [38:0] req1_b,
    output logic        req1_ready,
    output logic        req1_done,
    output logic [37:0] res,
    output logic        res_err,
    output logic        mul_load,
    output logic        mul_op_mul,
    output logic        mul_kill,
    output logic [38:0] mul_a,
    output logic [38:0] mul_b,
    input  logic [37:0] mul_res,
    input  logic        mul_ready
);

    typedef enum logic [1:0] {IDLE, LOAD, WAIT} state_t;

    localparam logic [3:0] WDOG_LAST = 4'(WDOG_CYCLES - 1);

    state_t     state;
    state_t     state_nxt;
    logic       last;
    logic       owner;
    logic       grant;
    logic       hs;
    logic       capture;
    logic       abort;
    logic [3:0] wdog;

    // on a tie the requester that did not complete last wins
    always_comb begin
        if (req0_valid && req1_valid) begin
            grant = ~last;
        end else begin
            grant = req1_valid;
        end
    end

    assign req0_ready = n_reset && (state == IDLE) && !kill
                        && req0_valid && !grant;
    assign req1_ready = n_reset && (state == IDLE) && !kill
                        && req1_valid && grant;
    assign mul_load   = (state == LOAD);
    assign mul_op_mul = mul_load;

    always_comb begin
        state_nxt = state;
        hs        = 1'b0;
        capture   = 1'b0;
        abort     = 1'b0;
        unique case (state)
            IDLE: begin
                if (req0_ready || req1_ready) begin
                    hs        = 1'b1;
                    state_nxt = LOAD;
                end
            end
            LOAD: begin
                state_nxt = kill ? IDLE : WAIT;
            end
            WAIT: begin
                if (kill) begin
                    state_nxt = IDLE;
                end else if (mul_ready) begin
                    capture   = 1'b1;
                    state_nxt = IDLE;
                end else if (wdog == WDOG_LAST) begin
                    abort     = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            state     <= IDLE;
            last      <= 1'b1;
            owner     <= 1'b0;
            wdog      <= '0;
            mul_a     <= '0;
            mul_b     <= '0;
            res       <= '0;
            res_err   <= 1'b0;
            req0_done <= 1'b0;
            req1_done <= 1'b0;
            mul_kill  <= 1'b0;
        end else begin
            state     <= state_nxt;
            wdog      <= (state == WAIT) ? wdog + 4'd1 : 4'd0;
            res_err   <= abort;
            req0_done <= (capture || abort) && !owner;
            req1_done <= (capture || abort) && owner;
            mul_kill  <= abort || (kill && (state != IDLE));
            if (hs) begin
                owner <= grant;
                mul_a <= grant ? req1_a : req0_a;
                mul_b <= grant ? req1_b : req0_b;
            end
            if (capture) begin
                res  <= mul_res;
                last <= owner;
            end else if (abort) begin
                res  <= '0;
                last <= owner;
            end
        end
    end

endmodule
